// File: rtl/pd_pkg.sv
// Shared definitions for the packet TX scheduler: FSM state encoding,
// packet geometry and PID values.
package pd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } pd_state_e;

  localparam int unsigned PD_PKT_WORDS  = 20;
  localparam logic [7:0]  PD_PID_RESULT = 8'h01;
  localparam logic [7:0]  PD_PID_STATUS = 8'h02;
  localparam int unsigned PD_CNT_W      = 5;

endpackage

// File: rtl/flex_counter_fix.sv
// Enable-gated up-counter with synchronous clear; wraps to zero after
// reaching rollover_val_i.
module flex_counter_fix #(
  parameter int unsigned NUM_CNT_BITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    count_enable_i,
  input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
  output logic [NUM_CNT_BITS-1:0] count_o
);

  logic [NUM_CNT_BITS-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (count_enable_i) begin
      count_q <= (count_q == rollover_val_i) ? '0 : count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pd_tx_scheduler.sv
// Packet TX scheduler: arbitrates found-nonce results against status
// requests and streams one PKT_WORDS packet at a time into the TX FIFO.
module pd_tx_scheduler
  import pd_pkg::*;
#(
  parameter int unsigned PKT_WORDS  = PD_PKT_WORDS,
  parameter logic [7:0]  PID_RESULT = PD_PID_RESULT,
  parameter logic [7:0]  PID_STATUS = PD_PID_STATUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              result_valid,
  input  logic [17:0][15:0] result_hash,
  output logic              result_ready,
  input  logic              status_req,
  input  logic              host_empty,
  input  logic              fifo_full,
  output logic [17:0][15:0] valid_hash,
  output logic [7:0]        PID,
  output logic              PID_en,
  output logic              transmit_empty,
  output logic              transmit_empty_en,
  output logic              read_enable,
  output logic              busy,
  output logic              pkt_done
);

  localparam logic [PD_CNT_W-1:0] LAST_IDX = PD_CNT_W'(PKT_WORDS - 1);

  pd_state_e         state_q;
  logic              pending_q, pending_d;
  logic              status_take;
  logic [17:0][15:0] valid_hash_q;
  logic [7:0]        pid_q;
  logic [PD_CNT_W-1:0] word_idx;

  // A result offered in the same IDLE cycle wins, so the pending status
  // request is only consumed when no result is present.
  assign status_take = (state_q == ST_IDLE) && !result_valid && pending_q;
  assign pending_d   = status_req | (pending_q & ~status_take);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      valid_hash_q <= '0;
      pid_q        <= '0;
    end else begin
      pending_q <= pending_d;
      unique case (state_q)
        ST_IDLE: begin
          if (result_valid) begin
            valid_hash_q <= result_hash;
            pid_q        <= PID_RESULT;
            state_q      <= ST_LOAD;
          end else if (pending_q) begin
            valid_hash_q <= '0;
            pid_q        <= PID_STATUS;
            state_q      <= ST_LOAD;
          end
        end
        ST_LOAD: state_q <= ST_SEND;
        ST_SEND: begin
          if (read_enable && (word_idx == LAST_IDX)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  flex_counter_fix #(
    .NUM_CNT_BITS (PD_CNT_W)
  ) u_word_cnt (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (state_q == ST_DONE),
    .count_enable_i (read_enable),
    .rollover_val_i (LAST_IDX),
    .count_o        (word_idx)
  );

  assign result_ready      = (state_q == ST_IDLE);
  assign busy              = (state_q != ST_IDLE);
  assign pkt_done          = (state_q == ST_DONE);
  assign PID_en            = (state_q == ST_LOAD);
  assign transmit_empty_en = (state_q == ST_LOAD);
  assign transmit_empty    = (state_q == ST_LOAD) && host_empty;
  assign read_enable       = (state_q == ST_SEND) && !fifo_full;
  assign valid_hash        = valid_hash_q;
  assign PID               = pid_q;

endmodule

// File: tb/tb_pd_tx_scheduler.sv
// Directed bench for pd_tx_scheduler: packet timing, arbitration,
// backpressure, status capture and mid-packet reset.
module tb_pd_tx_scheduler;

  logic              clk = 1'b0;
  logic              rst;
  logic              result_valid;
  logic [17:0][15:0] result_hash;
  logic              result_ready;
  logic              status_req;
  logic              host_empty;
  logic              fifo_full;
  logic [17:0][15:0] valid_hash;
  logic [7:0]        PID;
  logic              PID_en;
  logic              transmit_empty;
  logic              transmit_empty_en;
  logic              read_enable;
  logic              busy;
  logic              pkt_done;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_load = 0;

  always #5 clk = ~clk;

  pd_tx_scheduler #(
    .PKT_WORDS  (20),
    .PID_RESULT (8'h01),
    .PID_STATUS (8'h02)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .result_valid      (result_valid),
    .result_hash       (result_hash),
    .result_ready      (result_ready),
    .status_req        (status_req),
    .host_empty        (host_empty),
    .fifo_full         (fifo_full),
    .valid_hash        (valid_hash),
    .PID               (PID),
    .PID_en            (PID_en),
    .transmit_empty    (transmit_empty),
    .transmit_empty_en (transmit_empty_en),
    .read_enable       (read_enable),
    .busy              (busy),
    .pkt_done          (pkt_done)
  );

  always @(negedge clk) begin
    if (rst === 1'b0 && PID_en === 1'b1) n_load++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Runs from the current cycle until pkt_done (bounded); status_req is
  // pulsed in absolute cycles sa and sb.
  task automatic measure(input int start, input int sa, input int sb,
                         output int n_re, output int n_te, output int done_c);
    int c;
    c = start; n_re = 0; n_te = 0; done_c = -1;
    for (int k = 0; k < 200; k++) begin
      next();
      c++;
      status_req = (c == sa) || (c == sb);
      @(negedge clk);
      if (read_enable) n_re++;
      if (transmit_empty_en) n_te++;
      if (pkt_done) begin
        done_c = c;
        break;
      end
    end
    status_req = 1'b0;
  endtask

  task automatic offer_result(input logic [15:0] w17, input logic [15:0] base);
    next();
    for (int i = 0; i < 18; i++) result_hash[i] = base + 16'(i);
    result_hash[17] = w17;
    result_valid    = 1'b1;
  endtask

  int nre, nte, dn, b, n0, stalls, re_stall, c;

  initial begin
    rst = 1'b1; result_valid = 1'b0; status_req = 1'b0;
    host_empty = 1'b0; fifo_full = 1'b0; result_hash = '0;
    repeat (3) next();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", result_ready, 1);
    check("rst_busy",  busy, 0);
    check("rst_re",    read_enable, 0);
    check("rst_done",  pkt_done, 0);
    check("rst_pid_en", PID_en, 0);
    check("rst_te_en", transmit_empty_en, 0);
    check("rst_pid",   PID, 0);
    check("rst_hash_zero", valid_hash == '0, 1);

    // Result-only packet with host_empty captured in LOAD
    offer_result(16'hABCD, 16'h1000);
    @(negedge clk);
    check("A_ready_idle", result_ready, 1);
    next();
    result_valid = 1'b0; host_empty = 1'b1; result_hash = '0;
    @(negedge clk);
    check("A_load_busy",   busy, 1);
    check("A_load_pid_en", PID_en, 1);
    check("A_load_pid",    PID, 8'h01);
    check("A_load_te_en",  transmit_empty_en, 1);
    check("A_load_te",     transmit_empty, 1);
    check("A_load_re",     read_enable, 0);
    check("A_load_ready",  result_ready, 0);
    check("A_hash_w17",    valid_hash[17], 16'hABCD);
    check("A_hash_w3",     valid_hash[3], 16'h1003);
    host_empty = 1'b0;
    measure(2, -1, -1, nre, nte, dn);
    check("A_re_pulses",   nre, 20);
    check("A_te_en_send",  nte, 0);
    check("A_done_cycle",  dn, 23);
    check("A_hash_stable", valid_hash[17], 16'hABCD);
    next();
    @(negedge clk);
    check("A_idle_busy",  busy, 0);
    check("A_idle_ready", result_ready, 1);

    // Simultaneous result and status request: result first
    offer_result(16'h5A5A, 16'h0001);
    status_req = 1'b1;
    @(negedge clk);
    next();
    result_valid = 1'b0; status_req = 1'b0;
    @(negedge clk);
    check("B_load1_pid", PID, 8'h01);
    check("B_load1_w0",  valid_hash[0], 16'h0001);
    measure(2, -1, -1, nre, nte, dn);
    check("B_pkt1_re",   nre, 20);
    check("B_pkt1_done", dn, 23);
    next();
    @(negedge clk);
    check("B_gap_busy", busy, 0);
    next();
    @(negedge clk);
    check("B_load2_pid_en", PID_en, 1);
    check("B_load2_pid",    PID, 8'h02);
    check("B_load2_zero",   valid_hash == '0, 1);
    measure(25, -1, -1, nre, nte, dn);
    check("B_pkt2_re",   nre, 20);
    check("B_pkt2_done", dn, 46);
    b = 0;
    repeat (8) begin
      next();
      @(negedge clk);
      if (busy) b++;
    end
    check("B_no_extra", b, 0);

    // Backpressure on words 5..9
    offer_result(16'h1234, 16'h2000);
    @(negedge clk);
    next();
    result_valid = 1'b0;
    @(negedge clk);
    c = 2; nre = 0; stalls = 0; re_stall = 0; dn = -1;
    for (int k = 0; k < 200; k++) begin
      next();
      c++;
      fifo_full = (nre == 5) && (stalls < 5);
      if (fifo_full) stalls++;
      @(negedge clk);
      if (read_enable) begin
        nre++;
        if (fifo_full) re_stall++;
      end
      if (pkt_done) begin
        dn = c;
        break;
      end
    end
    fifo_full = 1'b0;
    check("C_stalls",    stalls, 5);
    check("C_re_stall",  re_stall, 0);
    check("C_re_pulses", nre, 20);
    check("C_done",      dn, 28);
    check("C_hash_w17",  valid_hash[17], 16'h1234);
    next();

    // Two status pulses during one busy packet yield one status packet
    n0 = n_load;
    offer_result(16'h7777, 16'h3000);
    @(negedge clk);
    next();
    result_valid = 1'b0;
    @(negedge clk);
    measure(2, 5, 12, nre, nte, dn);
    check("D_pkt_done", dn, 23);
    repeat (30) next();
    @(negedge clk);
    check("D_loads",     n_load - n0, 2);
    check("D_last_pid",  PID, 8'h02);
    check("D_idle_busy", busy, 0);

    // Reset after 10 words, with a status request pending
    offer_result(16'h9999, 16'h4000);
    @(negedge clk);
    next();
    result_valid = 1'b0;
    @(negedge clk);
    nre = 0;
    for (int k = 0; k < 50 && nre < 10; k++) begin
      next();
      status_req = (k == 1);
      @(negedge clk);
      if (read_enable) nre++;
    end
    status_req = 1'b0;
    check("E_words_before_rst", nre, 10);
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    check("E_re",    read_enable, 0);
    check("E_busy",  busy, 0);
    check("E_ready", result_ready, 1);
    check("E_hash_zero", valid_hash == '0, 1);
    check("E_pid",   PID, 0);
    b = 0;
    repeat (10) begin
      next();
      @(negedge clk);
      if (busy || PID_en) b++;
    end
    check("E_pending_cleared", b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pd_tx_scheduler.md
PD_TX_SCHEDULER -- requirements
Module: pd_tx_scheduler

Interface
REQ-001 SHALL have parameter PKT_WORDS, default 20, meaning 16-bit words per packet (2 header + 18 payload).
REQ-002 SHALL have parameter PID_RESULT, default 8'h01, meaning PID for nonce-found packets.
REQ-003 SHALL have parameter PID_STATUS, default 8'h02, meaning PID for status-response packets.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 result_valid  in  1  miner offers a found hash+nonce.
REQ-008 result_hash  in  [17:0][15:0]  hash+nonce payload, sampled when result_valid && result_ready.
REQ-009 result_ready  out  1  scheduler accepts result this cycle.
REQ-010 status_req  in  1  single-cycle pulse requesting a status packet.
REQ-011 host_empty  in  1  host-side transmit-empty status, captured at packet start.
REQ-012 fifo_full  in  1  downstream TX FIFO cannot accept a word.
REQ-013 valid_hash  out  [17:0][15:0]  registered payload driven to the packet formatter.
REQ-014 PID, PID_en  out  8, 1  packet PID and its one-cycle load strobe.
REQ-015 transmit_empty, transmit_empty_en  out  1, 1  status bit and its one-cycle load strobe.
REQ-016 read_enable  out  1  advance formatter word counter; also the TX FIFO write strobe.
REQ-017 busy  out  1  high from LOAD through DONE.
REQ-018 pkt_done  out  1  one-cycle pulse after the last word is written.

Function
REQ-019 SHALL implement FSM IDLE -> LOAD -> SEND -> DONE -> IDLE.
REQ-020 IDLE: SHALL go to LOAD when result_valid or a pending status request exists; result has priority.
REQ-021 result_ready SHALL be high only in IDLE; the accepting edge loads result_hash into valid_hash and selects PID_RESULT.
REQ-022 A status packet SHALL load valid_hash with all zeros and select PID_STATUS.
REQ-023 status_req SHALL set a sticky pending bit, cleared when a status packet enters LOAD; a pulse arriving in the clear cycle SHALL re-set it (set wins).
REQ-024 LOAD (exactly 1 cycle): PID_en=1 and transmit_empty_en=1, with transmit_empty = host_empty sampled that cycle; read_enable=0.
REQ-025 SEND: read_enable = !fifo_full; internal word index (0..PKT_WORDS-1) SHALL increment only when read_enable=1.
REQ-026 SEND SHALL exit to DONE on the cycle read_enable=1 with index = PKT_WORDS-1; exactly PKT_WORDS read_enable pulses per packet, never more.
REQ-027 fifo_full held indefinitely SHALL stall SEND with index and valid_hash unchanged.
REQ-028 DONE (1 cycle): pkt_done=1, index cleared to 0, then IDLE.
REQ-029 valid_hash and PID SHALL be stable from LOAD until the next LOAD.
REQ-030 result_valid and status requests arriving while busy SHALL wait; no request is dropped.
REQ-031 Minimum packet latency, request to pkt_done, SHALL be PKT_WORDS+3 cycles with fifo_full=0.

Reset
REQ-032 rst SHALL force IDLE, index 0, pending bit 0, valid_hash 0, PID 0; all strobes, busy, and pkt_done 0; result_ready 1 in the cycle after reset.
REQ-033 rst mid-packet SHALL abort without further read_enable; the partial packet is the FIFO owner's concern.

Structure
REQ-034 SHALL place the state enum, PID_RESULT/PID_STATUS values, and PKT_WORDS in shared package pd_pkg.
REQ-035 SHALL instantiate one sub-module, flex_counter_fix (5-bit), for the word index; the FSM and payload register stay in pd_tx_scheduler.

Verification
REQ-036 Result only: result_valid=1, hash word17=16'hABCD, fifo_full=0 -> LOAD with PID=8'h01, 20 consecutive read_enable, pkt_done at cycle 23.
REQ-037 Simultaneous: result_valid and status_req in the same IDLE cycle -> result packet (PID 01) first, then status packet (PID 02, payload 0), no idle gap beyond the DONE and IDLE cycles.
REQ-038 Backpressure: fifo_full=1 for words 5-9 -> read_enable low those cycles, total pulses 20, index holds at 5.
REQ-039 Status capture: host_empty=1 during LOAD, then 0 -> transmit_empty=1 with transmit_empty_en for exactly one cycle.
REQ-040 Reset mid-SEND at word 10 -> next cycle IDLE, read_enable=0, busy=0, pending cleared, valid_hash=0.
REQ-041 Two status_req pulses during one busy packet -> exactly one status packet afterwards.
